// File: rtl/apb_pkg.sv
// Purpose : shared types and default widths for the APB requester block.
// Latency : n/a (declarations only).
// Backpres: n/a (declarations only).
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 8;
    localparam int unsigned APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_mst_state_t;

    // Response as returned to the command source, at the default data width.
    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } apb_rsp_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Purpose : counts ACCESS-phase wait cycles and flags when the timeout threshold is reached.
// Latency : expired_o is combinational from the count register; clear/enable take effect on the next edge.
// Backpres: none; the counter saturates at all-ones and never wraps.
// Ports   : pclk/prst clock and async active-low reset; clear_i zeroes the count;
//           enable_i increments it; expired_o is high while count == TIMEOUT_CYCLES-1.
module apb_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic pclk,
    input  logic prst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] THRESH  = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge pclk or negedge prst) begin
        if (!prst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A zero threshold means the timeout is disabled, so never expire.
    assign expired_o = (TIMEOUT_CYCLES != 0) && (cnt_q == THRESH);

endmodule

// File: rtl/apb_master_ctrl.sv
// Purpose : APB requester turning a valid/ready command into one APB transfer and one response.
// Latency : accept at E0, SETUP E0-E1, ACCESS from E1; zero-wait response valid after E2, +1 per wait state.
// Backpres: cmd_ready low from accept until the response is consumed; rsp held stable while rsp_ready=0.
// Ports   : pclk/prst clock and async active-low reset; cmd_* command in; rsp_* response out;
//           psel/penable/pwrite/paddr/pw_data APB request out; pr_data/pready/pslverr APB completion in.
module apb_master_ctrl
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = APB_ADDR_W,
    parameter int unsigned DATA_WIDTH     = APB_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk,
    input  logic                  prst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pw_data,
    input  logic [DATA_WIDTH-1:0] pr_data,
    input  logic                  pready,
    input  logic                  pslverr
);

    // Same field layout as apb_rsp_t, sized by this instance's DATA_WIDTH.
    typedef struct packed {
        logic [DATA_WIDTH-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } rsp_t;

    apb_mst_state_t        state_q, state_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    rsp_t                  rsp_q, rsp_d;
    logic                  timer_expired;

    apb_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .pclk     (pclk),
        .prst     (prst),
        .clear_i  (state_q == SETUP),
        .enable_i ((state_q == ACCESS) && !pready),
        .expired_o(timer_expired)
    );

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_d       = rsp_q;

        unique case (state_q)
            IDLE: begin
                // cmd_ready is still low on the first edge out of reset, so
                // a command can only be taken once it has been advertised.
                if (cmd_ready_q && cmd_valid) begin
                    paddr_d     = cmd_addr;
                    pwrite_d    = cmd_write;
                    pwdata_d    = cmd_write ? cmd_wdata : '0;
                    psel_d      = 1'b1;
                    cmd_ready_d = 1'b0;
                    state_d     = SETUP;
                end else begin
                    cmd_ready_d = 1'b1;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // pready is tested first so a completion on the threshold edge is not a timeout.
                if (pready) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_d.err     = pslverr;
                    rsp_d.timeout = 1'b0;
                    rsp_d.rdata   = (!pwrite_q && !pslverr) ? pr_data : '0;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end else if (timer_expired) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_d.err     = 1'b1;
                    rsp_d.timeout = 1'b1;
                    rsp_d.rdata   = '0;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge prst) begin
        if (!prst) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_q.rdata;
    assign rsp_err     = rsp_q.err;
    assign rsp_timeout = rsp_q.timeout;
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pw_data     = pwdata_q;

endmodule
